// File: rtl/seq_addsub_pkg.sv
// seq_addsub shared definitions: FSM encoding and
// chunk-count / index-width helpers.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int w, input int c);
        return w / c;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int w, input int c);
        return (c >= 1) && (c <= w) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// CHUNK-bit combinational ripple adder of full-adder cells.
// Exposes the carry into its top bit for overflow detection.
module seq_addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic c [0:CHUNK];

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o     = c[CHUNK];
    assign c_msb_in_o = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock,
// LSB first, with start/busy/done handshake.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("seq_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_c, b_c, sum_c;
    logic             c_out, c_msb;
    logic             last_c;

    // Select the operand slice addressed by the chunk index.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                a_c = a_q[i*CHUNK +: CHUNK];
                b_c = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign last_c = (idx_q == IW'(NCHUNK - 1));

    seq_addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i        (a_c),
        .b_i        (b_c),
        .cin_i      (carry_q),
        .sum_o      (sum_c),
        .cout_o     (c_out),
        .c_msb_in_o (c_msb)
    );

    // Next-state: accept in IDLE, one chunk per RUN edge, pulse DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = c_out;
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IW'(i)) begin
                        s_d[i*CHUNK +: CHUNK] = sum_c;
                    end
                end
                if (last_c) begin
                    cout_d  = c_out;
                    ovf_d   = c_msb ^ c_out;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Randomised self-checking bench for seq_addsub at CHUNK=4, 1, 16
// against an integer-arithmetic reference model.
module tb_seq_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busy_w [3];
    logic         done_w [3];
    logic         cout_w [3];
    logic         ovf_w  [3];
    logic [W-1:0] s_w    [3];

    // chunk edges per op: instance 0 CHUNK=4, 1 CHUNK=1, 2 CHUNK=16
    int nch [3] = '{4, 16, 1};

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy_w[0]), .done(done_w[0]),
        .s(s_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
    );

    seq_addsub #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy_w[1]), .done(done_w[1]),
        .s(s_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
    );

    seq_addsub #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy_w[2]), .done(done_w[2]),
        .s(s_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // returns {ovf, cout, s} from exact integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic sb,
                                          input logic ci);
        int   ux, uy, sx, sy, ures, sres;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            ures = ux - uy;
            sres = sx - sy;
            c    = (ux >= uy);
        end else begin
            ures = ux + uy + int'(ci);
            sres = sx + sy + int'(ci);
            c    = (ures >= 65536);
        end
        o = (sres > 32767) || (sres < -32768);
        return {o, c, ures[15:0]};
    endfunction

    task automatic rand_inputs();
        a   = 16'($urandom);
        b   = 16'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tsub, input logic tcin,
                          input int ncyc, input logic [2:0] mask,
                          input bit inj);
        logic [17:0] exp;
        logic [17:0] got  [3];
        int          dcnt [3];
        int          dcyc [3];
        int          bcnt [3];
        exp = model(ta, tb, tsub, tcin);
        for (int i = 0; i < 3; i++) begin
            got[i]  = '0;
            dcnt[i] = 0;
            dcyc[i] = -1;
            bcnt[i] = 0;
        end
        a     = ta;
        b     = tb;
        sub   = tsub;
        cin   = tcin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rand_inputs();
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 3; i++) begin
                if (busy_w[i]) bcnt[i]++;
                if (done_w[i]) begin
                    dcnt[i]++;
                    dcyc[i] = k;
                    got[i]  = {ovf_w[i], cout_w[i], s_w[i]};
                end
            end
            start = inj && (k == 2 || k == 4);
            if (start) rand_inputs();
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                chk($sformatf("i%0d ndone", i), 32'(dcnt[i]), 32'd1);
                chk($sformatf("i%0d done_cyc", i), 32'(dcyc[i]),
                    32'(nch[i]));
                chk($sformatf("i%0d s %h%s%h", i, ta, tsub ? "-" : "+", tb),
                    32'(got[i][15:0]), 32'(exp[15:0]));
                chk($sformatf("i%0d cout", i), 32'(got[i][16]),
                    32'(exp[16]));
                chk($sformatf("i%0d ovf", i), 32'(got[i][17]),
                    32'(exp[17]));
                if (ncyc > nch[i]) begin
                    chk($sformatf("i%0d busy_cycles", i), 32'(bcnt[i]),
                        32'(nch[i] + 1));
                    chk($sformatf("i%0d s_hold", i), 32'(s_w[i]),
                        32'(exp[15:0]));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        int nd;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d rst busy", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("i%0d rst done", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("i%0d rst s", i), 32'(s_w[i]), 32'd0);
            chk($sformatf("i%0d rst cout", i), 32'(cout_w[i]), 32'd0);
            chk($sformatf("i%0d rst ovf", i), 32'(ovf_w[i]), 32'd0);
        end
        idle(1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 20, 3'b111, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 20, 3'b111, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, 20, 3'b111, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 20, 3'b111, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 20, 3'b111, 1'b0);
        run_op(16'h0000, 16'h8000, 1'b1, 1'b0, 20, 3'b111, 1'b0);

        // starts during RUN and DONE must be ignored
        run_op(16'hA5A5, 16'h1111, 1'b0, 1'b1, 20, 3'b001, 1'b1);

        // earliest back-to-back start on the CHUNK=4 instance
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 5, 3'b001, 1'b0);
        run_op(16'h1000, 16'h2001, 1'b1, 1'b0, 5, 3'b001, 1'b0);
        idle(25);

        // async reset in the second RUN cycle
        a     = 16'h00F3;
        b     = 16'h0004;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst busy", 32'(busy_w[0]), 32'd1);
        chk("pre_rst s", 32'(s_w[0]), 32'h0007);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d arst busy", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("i%0d arst done", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("i%0d arst s", i), 32'(s_w[i]), 32'd0);
            chk($sformatf("i%0d arst cout", i), 32'(cout_w[i]), 32'd0);
            chk($sformatf("i%0d arst ovf", i), 32'(ovf_w[i]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0]) nd++;
        end
        chk("arst no_done", 32'(nd), 32'd0);
        run_op(16'h00F3, 16'h0004, 1'b0, 1'b0, 20, 3'b111, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), 20, 3'b111, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
